// File: rtl/calc_pkg.sv
// Shared types and helpers for the Lab03 calculator pipeline: step encodings,
// operation codes, operand/result widths and the add/subtract magnitude function.
package calc_pkg;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned RES_W  = 5;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_A0  = 2'b00,
    S_A1  = 2'b01,
    S_RES = 2'b10
  } state_t;

  typedef struct packed {
    logic [RES_W-1:0] mag;
    logic             neg;
  } calc_t;

  // Sign-magnitude result on zero-extended operands; bit 4 only ever set by add.
  function automatic calc_t calc_result(input logic [OPND_W-1:0] a,
                                        input logic [OPND_W-1:0] b,
                                        input logic              op);
    calc_t            res;
    logic [RES_W-1:0] ea;
    logic [RES_W-1:0] eb;
    ea      = {1'b0, a};
    eb      = {1'b0, b};
    res.neg = 1'b0;
    if (op == OP_ADD) begin
      res.mag = ea + eb;
    end else if (ea >= eb) begin
      res.mag = ea - eb;
    end else begin
      res.mag = eb - ea;
      res.neg = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on each accepted released-to-pressed transition.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/operand_entry_fsm.sv
// Operand entry for the calculator display: A0 -> A1 -> result -> clear, one
// debounced KEY press per step. Define OPCAP_TIMEOUT_EN for auto-clear in S_RES.
module operand_entry_fsm
  import calc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPND_W-1:0] sw,
  input  logic              op_sw,
  input  logic              key_n,
  output logic [OPND_W-1:0] a0,
  output logic [OPND_W-1:0] a1,
  output logic              op,
  output logic [RES_W-1:0]  result,
  output logic              neg,
  output logic              res_valid,
  output logic [1:0]        state
);

  logic              w_press;
  logic              w_timeout;
  logic              w_clear;
  calc_t             w_calc;

  state_t            r_state,  w_state_nxt;
  logic [OPND_W-1:0] r_a0,     w_a0_nxt;
  logic [OPND_W-1:0] r_a1,     w_a1_nxt;
  logic              r_op,     w_op_nxt;
  logic [RES_W-1:0]  r_res,    w_res_nxt;
  logic              r_neg,    w_neg_nxt;
  logic              r_valid,  w_valid_nxt;
  logic              r_load,   w_load_nxt;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .press (w_press)
  );

  assign w_calc = calc_result(r_a0, r_a1, r_op);

`ifdef OPCAP_TIMEOUT_EN
  logic [27:0] r_idle;

  assign w_timeout = (r_state == S_RES) && (r_idle == 28'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if ((r_state != S_RES) || w_press || w_timeout) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_a0_nxt    = r_a0;
    w_a1_nxt    = r_a1;
    w_op_nxt    = r_op;
    w_res_nxt   = r_res;
    w_neg_nxt   = r_neg;
    w_valid_nxt = r_valid;
    w_load_nxt  = 1'b0;
    w_clear     = 1'b0;

    // Result lands one cycle after the A1 capture, from the registered operands.
    if (r_load) begin
      w_res_nxt   = w_calc.mag;
      w_neg_nxt   = w_calc.neg;
      w_valid_nxt = 1'b1;
    end

    case (r_state)
      S_A0: if (w_press) begin
        w_a0_nxt    = sw;
        w_state_nxt = S_A1;
      end
      S_A1: if (w_press) begin
        w_a1_nxt    = sw;
        w_op_nxt    = op_sw;
        w_state_nxt = S_RES;
        w_load_nxt  = 1'b1;
      end
      S_RES:   w_clear = w_press || w_timeout;
      default: w_clear = 1'b1;
    endcase

    if (w_clear) begin
      w_state_nxt = S_A0;
      w_a0_nxt    = '0;
      w_a1_nxt    = '0;
      w_op_nxt    = OP_ADD;
      w_res_nxt   = '0;
      w_neg_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
      w_load_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A0;
      r_a0    <= '0;
      r_a1    <= '0;
      r_op    <= OP_ADD;
      r_res   <= '0;
      r_neg   <= 1'b0;
      r_valid <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a0    <= w_a0_nxt;
      r_a1    <= w_a1_nxt;
      r_op    <= w_op_nxt;
      r_res   <= w_res_nxt;
      r_neg   <= w_neg_nxt;
      r_valid <= w_valid_nxt;
      r_load  <= w_load_nxt;
    end
  end

  assign a0        = r_a0;
  assign a1        = r_a1;
  assign op        = r_op;
  assign result    = r_res;
  assign neg       = r_neg;
  assign res_valid = r_valid;
  assign state     = r_state;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Bench for operand_entry_fsm with DEB_CYCLES=4, TIMEOUT_CYCLES=20: directed
// scenarios with literal expectations plus randomized presses, bounce and switch noise.
module tb_operand_entry_fsm;

  localparam int unsigned DEB = 4;
  localparam int unsigned TO  = 20;
`ifdef OPCAP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       op_sw;
  logic       key_n;
  logic [3:0] a0, a1;
  logic       op, neg, res_valid;
  logic [4:0] result;
  logic [1:0] state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          cmp_en   = 1'b0;

  operand_entry_fsm #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .op_sw     (op_sw),
    .key_n     (key_n),
    .a0        (a0),
    .a1        (a1),
    .op        (op),
    .result    (result),
    .neg       (neg),
    .res_valid (res_valid),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a key level is accepted once the synchronized input (two
  // samples old) has disagreed with it on DEB consecutive edges; an accepted
  // press acts on the following edge.
  int  m_a0, m_a1, m_op, m_res, m_neg, m_valid, m_state;
  int  m_run, m_idle;
  bit  m_k1, m_k2, m_lvl, m_press, m_load;

  task automatic model_clear();
    m_a0 = 0; m_a1 = 0; m_op = 0; m_res = 0; m_neg = 0; m_valid = 0;
    m_state = 0; m_load = 1'b0; m_idle = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit pr;
    int d;
    if (!rst_n) begin
      model_clear();
      m_k1 = 1'b1; m_k2 = 1'b1; m_lvl = 1'b1; m_run = 0; m_press = 1'b0;
    end else begin
      pr = m_press;
      m_press = 1'b0;
      if (m_load) begin
        if (m_op == 0) begin
          m_res = m_a0 + m_a1; m_neg = 0;
        end else begin
          d = m_a0 - m_a1;
          m_res = (d < 0) ? -d : d;
          m_neg = (d < 0) ? 1 : 0;
        end
        m_valid = 1; m_load = 1'b0;
      end
      case (m_state)
        0: if (pr) begin m_a0 = int'(sw); m_state = 1; end
        1: if (pr) begin
             m_a1 = int'(sw); m_op = int'(op_sw); m_state = 2; m_load = 1'b1; m_idle = 0;
           end
        default: begin
          if (pr) model_clear();
          else if (TO_EN) begin
            m_idle++;
            if (m_idle == int'(TO)) model_clear();
          end
        end
      endcase
      if (m_k2 != m_lvl) begin
        m_run++;
        if (m_run == int'(DEB)) begin
          m_lvl = m_k2; m_run = 0; m_press = !m_k2;
        end
      end else m_run = 0;
      m_k2 = m_k1;
      m_k1 = key_n;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (cmp_en) begin
      chk("state", state, m_state);
      chk("a0", a0, m_a0);
      chk("a1", a1, m_a1);
      chk("op", op, m_op);
      chk("result", result, m_res);
      chk("neg", neg, m_neg);
      chk("res_valid", res_valid, m_valid);
    end
  end

  task automatic do_press(input logic [3:0] v, input logic o);
    @(negedge clk);
    sw = v; op_sw = o; key_n = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    key_n = 1'b1;
    repeat (DEB + 4) @(negedge clk);
  endtask

  task automatic bounce(input int unsigned w, input int unsigned n);
    repeat (n) begin
      @(negedge clk) key_n = 1'b0;
      repeat (w - 1) @(negedge clk);
      @(negedge clk) key_n = 1'b1;
      repeat (w - 1) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_n = 1'b1; sw = '0; op_sw = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_a0", a0, 0);
    chk("rst_valid", res_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    cmp_en = 1'b1;

    repeat (100) @(negedge clk);
    chk("idle_state", state, 0);

    // Press latency: a0 changes on the edge after DEB+2 edges from the key fall.
    @(negedge clk);
    sw = 4'd5; op_sw = 1'b0; key_n = 1'b0;
    repeat (DEB + 2) @(posedge clk);
    #1 chk("lat_before", state, 0);
    @(posedge clk);
    #1 chk("lat_state", state, 1);
    chk("lat_a0", a0, 5);
    @(negedge clk);
    repeat (3) @(negedge clk);
    key_n = 1'b1;
    repeat (DEB + 4) @(negedge clk);

    do_press(4'd3, 1'b0);
    chk("add_a0", a0, 5);
    chk("add_a1", a1, 3);
    chk("add_state", state, 2);
    chk("add_res", result, 8);
    chk("add_neg", neg, 0);
    chk("add_valid", res_valid, 1);

    do_press(4'd0, 1'b0);
    chk("clr_state", state, 0);
    chk("clr_a0", a0, 0);
    chk("clr_a1", a1, 0);
    chk("clr_res", result, 0);
    chk("clr_valid", res_valid, 0);

    do_press(4'd3, 1'b1);
    do_press(4'd9, 1'b1);
    chk("sub_res", result, 6);
    chk("sub_neg", neg, 1);
    chk("sub_op", op, 1);
    do_press(4'd0, 1'b0);

    do_press(4'd15, 1'b0);
    do_press(4'd15, 1'b0);
    chk("max_res", result, 30);
    chk("max_bit4", result[4], 1);
    do_press(4'd0, 1'b0);

    do_press(4'd7, 1'b1);
    do_press(4'd7, 1'b1);
    chk("eq_res", result, 0);
    chk("eq_neg", neg, 0);
    chk("eq_valid", res_valid, 1);
    do_press(4'd0, 1'b0);

    // Bounce at 2-cycle half period never satisfies the stability window.
    bounce(2, 10);
    repeat (DEB + 4) @(negedge clk);
    chk("bounce_state", state, 0);

    // Reset mid-sequence, then mid-debounce.
    do_press(4'd6, 1'b0);
    chk("pre_rst_state", state, 1);
    @(negedge clk) sw = 4'd2;
    #2 rst_n = 1'b0;
    #1 chk("midrst_state", state, 0);
    chk("midrst_a0", a0, 0);
    @(negedge clk) key_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk) key_n = 1'b1;
    #2 rst_n = 1'b1;
    repeat (DEB + 4) @(negedge clk);
    chk("rst_deb_state", state, 0);
    do_press(4'd7, 1'b0);
    chk("after_rst_a0", a0, 7);
    chk("after_rst_state", state, 1);
    do_press(4'd1, 1'b0);

    if (TO_EN) begin
      repeat (30) @(negedge clk);
      chk("timeout_state", state, 0);
      chk("timeout_valid", res_valid, 0);
    end else begin
      repeat (1000) @(negedge clk);
      chk("hold_state", state, 2);
      chk("hold_res", result, 8);
      do_press(4'd0, 1'b0);
    end

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) bounce($urandom_range(1, DEB - 1), $urandom_range(1, 5));
      do_press(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 30)) begin
        @(negedge clk);
        sw = 4'($urandom);
        op_sw = 1'($urandom);
      end
    end

    repeat (5) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
- Upstream stage of the Lab03 calculator display.
- Captures two 4-bit operands and an add/subtract select from slide switches, one debounced KEY press per step.
- Computes the registered result and exposes a0, a1, op, result and sign for the display stage.
- Three-step sequential flow: enter A0, enter A1, show result, then clear.

Parameters:
- DEB_CYCLES, 500000, consecutive stable cycles a synchronized key level must hold before it is accepted (10 ms at 50 MHz).
- TIMEOUT_CYCLES, 250000000, idle cycles in S_RES before auto-clear (5 s at 50 MHz); used only with OPCAP_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- sw  in  4  operand value from slide switches
- op_sw  in  1  0 = add, 1 = subtract
- key_n  in  1  raw pushbutton, active-low, asynchronous to clk
- a0  out  4  latched first operand
- a1  out  4  latched second operand
- op  out  1  latched operation
- result  out  5  magnitude of result; bit 4 is the add carry
- neg  out  1  subtract result negative
- res_valid  out  1  result, neg and op are valid
- state  out  2  current step: 00 S_A0, 01 S_A1, 10 S_RES

Behaviour:
- Reset, asynchronous on rst_n low: a0=0, a1=0, op=0, result=0, neg=0, res_valid=0, state=S_A0, synchronizer flops=1 (released), debounce counter=0, accepted level=released.
- Input conditioning:
  - key_n passes through a 2-flop synchronizer.
  - The debounce counter increments while the synchronized level differs from the accepted level and clears otherwise.
  - When the counter reaches DEB_CYCLES-1, the accepted level flips and the counter clears.
  - An accepted released-to-pressed flip produces press, a 1-cycle internal pulse.
  - Each press must be followed by an accepted release before another press can occur.
  - Latency from a stable key_n edge to press is DEB_CYCLES+2 cycles.
- FSM, acting only on press; all other cycles hold state:
  - S_A0 + press: a0<=sw, next state S_A1.
  - S_A1 + press: a1<=sw, op<=op_sw, next state S_RES. On the following cycle, result, neg and res_valid=1 are registered.
  - S_RES + press: a0, a1, op, result, neg and res_valid all clear to 0 on the same edge; next state S_A0.
  - Encoding 11 is illegal and goes to S_A0 with all outputs cleared.
- Arithmetic, on 5-bit zero-extended operands:
  - add: result=a0+a1 (0..30), neg=0.
  - sub with a0>=a1: result=a0-a1, neg=0.
  - sub with a0<a1: result=a1-a0, neg=1. result[4] is always 0 for subtract.
  - Equal operands on subtract give result=0, neg=0.
- Boundaries:
  - sw and op_sw changes outside a press have no effect on the latched outputs.
  - Key bounce shorter than DEB_CYCLES produces no press.
  - rst_n asserted mid-debounce or mid-sequence returns to the reset values immediately; the first press after release latches a0.

Optional Feature:
- OPCAP_TIMEOUT_EN defined:
  - A 28-bit idle counter runs only in S_RES and clears on entry and on any press.
  - When it reaches TIMEOUT_CYCLES-1, the block performs the same clear as an S_RES press and moves to S_A0.
  - If a press and the timeout occur in the same cycle, a single clear happens.
- OPCAP_TIMEOUT_EN undefined: no counter; S_RES is held indefinitely.

Decomposition:
- Shared package calc_pkg:
  - state encodings S_A0, S_A1, S_RES
  - OP_ADD=0, OP_SUB=1
  - operand width 4 and result width 5
- Sub-module key_debounce (synchronizer, debounce counter, press pulse) with parameter DEB_CYCLES. It is reused later by other KEY inputs.
- The FSM and arithmetic stay in the top module.

Test Plan:
- All scenarios use DEB_CYCLES=4 and TIMEOUT_CYCLES=20.
- Reset then idle: all outputs 0, state=00; key_n held high for 100 cycles gives no transition.
- sw=5 press; sw=3, op_sw=0 press: a0=5, a1=3, state=10, one cycle later result=8, neg=0, res_valid=1.
- sw=3 press; sw=9, op_sw=1 press: result=6, neg=1. Repeat with operands 15 and 15 on add: result=30, result[4]=1.
- key_n toggling every 2 cycles for 40 cycles: no press and state unchanged. A clean low held 10 cycles gives exactly one press after DEB_CYCLES+2 cycles.
- Press in S_RES: a0, a1, result and res_valid all 0 and state=00. rst_n pulsed low in S_A1: immediate reset values.
- With OPCAP_TIMEOUT_EN: 20 idle cycles in S_RES clear to S_A0. Without the macro: still in S_RES after 1000 cycles.
